// File: rtl/mem_write_checker_if.sv
// +--------------------------------------------------------------------------+
// | mem_write_checker_if                                                     |
// | Data-memory store port (strobe, address, data) seen by the checker.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface mem_write_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              MemWrite;
  logic [ADDR_W-1:0] Adr;
  logic [DATA_W-1:0] WriteData;

  modport master (output MemWrite, output Adr, output WriteData);
  modport slave  (input  MemWrite, input  Adr, input  WriteData);
endinterface

`default_nettype wire

// File: rtl/mem_write_checker.sv
// +--------------------------------------------------------------------------+
// | mem_write_checker                                                        |
// | Matches processor stores against a table of expected writes and        |
// | reports a sticky pass/fail verdict with cause code and offending store. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_write_checker #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_EXP  = 2,
  parameter int ORDERED  = 1,
  parameter int IGN_BASE = 96,
  parameter int IGN_SIZE = 4,
  parameter int TIMEOUT  = 1000,
  parameter int CNT_W    = 16,
  localparam int MC_W    = $clog2(NUM_EXP + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  mem_write_checker_if.slave        mem,
  input  logic [NUM_EXP*ADDR_W-1:0] exp_addr,
  input  logic [NUM_EXP*DATA_W-1:0] exp_data,
  output logic                      busy,
  output logic                      pass,
  output logic                      fail,
  output logic [1:0]                fail_code,
  output logic [ADDR_W-1:0]         fail_addr,
  output logic [DATA_W-1:0]         fail_data,
  output logic [MC_W-1:0]           match_cnt,
  output logic [CNT_W-1:0]          cycles
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam logic [1:0] c_code_none    = 2'd0;
  localparam logic [1:0] c_code_addr    = 2'd1;
  localparam logic [1:0] c_code_data    = 2'd2;
  localparam logic [1:0] c_code_timeout = 2'd3;

  // One extra bit so IGN_BASE+IGN_SIZE cannot wrap at the top of the map.
  localparam int              c_aw1       = ADDR_W + 1;
  localparam logic [ADDR_W:0] c_ign_lo    = c_aw1'(IGN_BASE);
  localparam logic [ADDR_W:0] c_ign_hi    = c_aw1'(IGN_BASE) + c_aw1'(IGN_SIZE);
  localparam bit              c_ign_en    = (IGN_SIZE != 0);
  localparam bit              c_to_en     = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] c_to_last  = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [MC_W-1:0] c_last_match = MC_W'(NUM_EXP - 1);

  state_t               state_q,     state_d;
  logic [MC_W-1:0]      match_cnt_q, match_cnt_d;
  logic [NUM_EXP-1:0]   mask_q,      mask_d;
  logic [CNT_W-1:0]     cycles_q,    cycles_d;
  logic [1:0]           fail_code_q, fail_code_d;
  logic [ADDR_W-1:0]    fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]    fail_data_q, fail_data_d;

  logic                 eligible;
  logic                 hit;
  logic                 addr_known;
  logic [NUM_EXP-1:0]   hit_mask;
  logic                 in_window;

  // Table lookup: hit selects the lowest eligible entry matching both fields;
  // addr_known flags an eligible entry whose address alone matches.
  always_comb begin
    eligible   = 1'b0;
    hit        = 1'b0;
    addr_known = 1'b0;
    hit_mask   = '0;
    for (int i = 0; i < NUM_EXP; i++) begin
      if (ORDERED != 0) begin
        eligible = (MC_W'(i) == match_cnt_q);
      end else begin
        eligible = !mask_q[i];
      end
      if (eligible && (mem.Adr == exp_addr[i*ADDR_W +: ADDR_W])) begin
        addr_known = 1'b1;
        if (!hit && (mem.WriteData == exp_data[i*DATA_W +: DATA_W])) begin
          hit         = 1'b1;
          hit_mask[i] = 1'b1;
        end
      end
    end
  end

  assign in_window = c_ign_en
                   && ({1'b0, mem.Adr} >= c_ign_lo)
                   && ({1'b0, mem.Adr} <  c_ign_hi);

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    mask_d      = mask_q;
    cycles_d    = cycles_q;
    fail_code_d = fail_code_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;

    case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start) begin
          state_d     = ST_RUN;
          match_cnt_d = '0;
          mask_d      = '0;
          cycles_d    = '0;
          fail_code_d = c_code_none;
          fail_addr_d = '0;
          fail_data_d = '0;
        end
      end

      ST_RUN: begin
        if (cycles_q != '1) begin
          cycles_d = cycles_q + CNT_W'(1);
        end

        if (mem.MemWrite) begin
          if (hit) begin
            match_cnt_d = match_cnt_q + MC_W'(1);
            mask_d      = mask_q | hit_mask;
            if (match_cnt_q == c_last_match) begin
              state_d = ST_PASS;
            end
          end else if (!in_window) begin
            state_d     = ST_FAIL;
            fail_code_d = addr_known ? c_code_data : c_code_addr;
            fail_addr_d = mem.Adr;
            fail_data_d = mem.WriteData;
          end
        end

        // A store that decides the run on the timeout cycle takes precedence.
        if ((state_d == ST_RUN) && c_to_en && (cycles_q == c_to_last)) begin
          state_d     = ST_FAIL;
          fail_code_d = c_code_timeout;
          fail_addr_d = '0;
          fail_data_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      match_cnt_q <= '0;
      mask_q      <= '0;
      cycles_q    <= '0;
      fail_code_q <= c_code_none;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      mask_q      <= mask_d;
      cycles_q    <= cycles_d;
      fail_code_q <= fail_code_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign pass      = (state_q == ST_PASS);
  assign fail      = (state_q == ST_FAIL);
  assign fail_code = fail_code_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign match_cnt = match_cnt_q;
  assign cycles    = cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_write_checker.sv
// +--------------------------------------------------------------------------+
// | tb_mem_write_checker                                                     |
// | Directed bench: four checker configurations share one store bus.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_write_checker;

  logic clk;
  logic reset;
  logic start_ord, start_any, start_to, start_ign;
  int   n_cmp;
  int   n_err;

  mem_write_checker_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  // Two-entry table: entry 0 = (100,7), entry 1 = (104,9).
  logic [63:0] exp2_addr;
  logic [63:0] exp2_data;
  logic [31:0] exp1_addr;
  logic [31:0] exp1_data;

  logic        ord_busy, ord_pass, ord_fail;
  logic [1:0]  ord_code, ord_mcnt;
  logic [31:0] ord_faddr, ord_fdata;
  logic [15:0] ord_cyc;

  logic        any_busy, any_pass, any_fail;
  logic [1:0]  any_code, any_mcnt;
  logic [31:0] any_faddr, any_fdata;
  logic [15:0] any_cyc;

  logic        to_busy, to_pass, to_fail;
  logic [1:0]  to_code, to_mcnt;
  logic [31:0] to_faddr, to_fdata;
  logic [15:0] to_cyc;

  logic        ign_busy, ign_pass, ign_fail;
  logic [1:0]  ign_code;
  logic [0:0]  ign_mcnt;
  logic [31:0] ign_faddr, ign_fdata;
  logic [15:0] ign_cyc;

  mem_write_checker #(.NUM_EXP(2), .ORDERED(1), .IGN_BASE(96), .IGN_SIZE(4), .TIMEOUT(1000)) u_ord (
    .clk(clk), .reset(reset), .start(start_ord), .mem(bus),
    .exp_addr(exp2_addr), .exp_data(exp2_data),
    .busy(ord_busy), .pass(ord_pass), .fail(ord_fail), .fail_code(ord_code),
    .fail_addr(ord_faddr), .fail_data(ord_fdata), .match_cnt(ord_mcnt), .cycles(ord_cyc));

  mem_write_checker #(.NUM_EXP(2), .ORDERED(0), .IGN_BASE(96), .IGN_SIZE(4), .TIMEOUT(1000)) u_any (
    .clk(clk), .reset(reset), .start(start_any), .mem(bus),
    .exp_addr(exp2_addr), .exp_data(exp2_data),
    .busy(any_busy), .pass(any_pass), .fail(any_fail), .fail_code(any_code),
    .fail_addr(any_faddr), .fail_data(any_fdata), .match_cnt(any_mcnt), .cycles(any_cyc));

  mem_write_checker #(.NUM_EXP(2), .ORDERED(1), .IGN_BASE(96), .IGN_SIZE(4), .TIMEOUT(20)) u_to (
    .clk(clk), .reset(reset), .start(start_to), .mem(bus),
    .exp_addr(exp2_addr), .exp_data(exp2_data),
    .busy(to_busy), .pass(to_pass), .fail(to_fail), .fail_code(to_code),
    .fail_addr(to_faddr), .fail_data(to_fdata), .match_cnt(to_mcnt), .cycles(to_cyc));

  mem_write_checker #(.NUM_EXP(1), .ORDERED(1), .IGN_BASE(96), .IGN_SIZE(8), .TIMEOUT(1000)) u_ign (
    .clk(clk), .reset(reset), .start(start_ign), .mem(bus),
    .exp_addr(exp1_addr), .exp_data(exp1_data),
    .busy(ign_busy), .pass(ign_pass), .fail(ign_fail), .fail_code(ign_code),
    .fail_addr(ign_faddr), .fail_data(ign_fdata), .match_cnt(ign_mcnt), .cycles(ign_cyc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.MemWrite  = 1'b1;
    bus.Adr       = a;
    bus.WriteData = d;
    tick();
    bus.MemWrite  = 1'b0;
  endtask

  task automatic pulse_start(input int which);
    case (which)
      0:       start_ord = 1'b1;
      1:       start_any = 1'b1;
      2:       start_to  = 1'b1;
      default: start_ign = 1'b1;
    endcase
    tick();
    start_ord = 1'b0;
    start_any = 1'b0;
    start_to  = 1'b0;
    start_ign = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (ord_busy  !== 1'b0)  begin n_err++; $display("FAIL rst_busy: got %0d expected 0", ord_busy); end
    n_cmp++; if (ord_pass  !== 1'b0)  begin n_err++; $display("FAIL rst_pass: got %0d expected 0", ord_pass); end
    n_cmp++; if (ord_fail  !== 1'b0)  begin n_err++; $display("FAIL rst_fail: got %0d expected 0", ord_fail); end
    n_cmp++; if (ord_code  !== 2'd0)  begin n_err++; $display("FAIL rst_code: got %0d expected 0", ord_code); end
    n_cmp++; if (ord_faddr !== 32'd0) begin n_err++; $display("FAIL rst_faddr: got %0d expected 0", ord_faddr); end
    n_cmp++; if (ord_fdata !== 32'd0) begin n_err++; $display("FAIL rst_fdata: got %0d expected 0", ord_fdata); end
    n_cmp++; if (ord_mcnt  !== 2'd0)  begin n_err++; $display("FAIL rst_mcnt: got %0d expected 0", ord_mcnt); end
    n_cmp++; if (ord_cyc   !== 16'd0) begin n_err++; $display("FAIL rst_cycles: got %0d expected 0", ord_cyc); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_ordered_pass();
    pulse_start(0);
    n_cmp++; if (ord_busy !== 1'b1)  begin n_err++; $display("FAIL ord_start_busy: got %0d expected 1", ord_busy); end
    n_cmp++; if (ord_cyc  !== 16'd0) begin n_err++; $display("FAIL ord_start_cycles: got %0d expected 0", ord_cyc); end
    store(32'd96, 32'd3);
    n_cmp++; if (ord_mcnt !== 2'd0)  begin n_err++; $display("FAIL ord_scratch_mcnt: got %0d expected 0", ord_mcnt); end
    n_cmp++; if (ord_busy !== 1'b1)  begin n_err++; $display("FAIL ord_scratch_busy: got %0d expected 1", ord_busy); end
    store(32'd100, 32'd7);
    n_cmp++; if (ord_mcnt !== 2'd1)  begin n_err++; $display("FAIL ord_first_mcnt: got %0d expected 1", ord_mcnt); end
    store(32'd104, 32'd9);
    n_cmp++; if (ord_pass !== 1'b1)  begin n_err++; $display("FAIL ord_pass: got %0d expected 1", ord_pass); end
    n_cmp++; if (ord_fail !== 1'b0)  begin n_err++; $display("FAIL ord_pass_fail: got %0d expected 0", ord_fail); end
    n_cmp++; if (ord_mcnt !== 2'd2)  begin n_err++; $display("FAIL ord_pass_mcnt: got %0d expected 2", ord_mcnt); end
    n_cmp++; if (ord_busy !== 1'b0)  begin n_err++; $display("FAIL ord_pass_busy: got %0d expected 0", ord_busy); end
    n_cmp++; if (ord_cyc  !== 16'd3) begin n_err++; $display("FAIL ord_pass_cycles: got %0d expected 3", ord_cyc); end
  endtask

  task automatic test_order_violation();
    pulse_start(0);
    n_cmp++; if (ord_pass !== 1'b0)  begin n_err++; $display("FAIL restart_pass: got %0d expected 0", ord_pass); end
    n_cmp++; if (ord_busy !== 1'b1)  begin n_err++; $display("FAIL restart_busy: got %0d expected 1", ord_busy); end
    n_cmp++; if (ord_mcnt !== 2'd0)  begin n_err++; $display("FAIL restart_mcnt: got %0d expected 0", ord_mcnt); end
    n_cmp++; if (ord_cyc  !== 16'd0) begin n_err++; $display("FAIL restart_cycles: got %0d expected 0", ord_cyc); end
    store(32'd104, 32'd9);
    n_cmp++; if (ord_fail  !== 1'b1)   begin n_err++; $display("FAIL ooo_fail: got %0d expected 1", ord_fail); end
    n_cmp++; if (ord_pass  !== 1'b0)   begin n_err++; $display("FAIL ooo_pass: got %0d expected 0", ord_pass); end
    n_cmp++; if (ord_code  !== 2'd1)   begin n_err++; $display("FAIL ooo_code: got %0d expected 1", ord_code); end
    n_cmp++; if (ord_faddr !== 32'd104) begin n_err++; $display("FAIL ooo_faddr: got %0d expected 104", ord_faddr); end
    n_cmp++; if (ord_fdata !== 32'd9)  begin n_err++; $display("FAIL ooo_fdata: got %0d expected 9", ord_fdata); end

    pulse_start(1);
    store(32'd104, 32'd9);
    n_cmp++; if (any_mcnt !== 2'd1) begin n_err++; $display("FAIL any_first_mcnt: got %0d expected 1", any_mcnt); end
    n_cmp++; if (any_busy !== 1'b1) begin n_err++; $display("FAIL any_first_busy: got %0d expected 1", any_busy); end
    store(32'd100, 32'd7);
    n_cmp++; if (any_pass !== 1'b1) begin n_err++; $display("FAIL any_pass: got %0d expected 1", any_pass); end
    n_cmp++; if (any_mcnt !== 2'd2) begin n_err++; $display("FAIL any_pass_mcnt: got %0d expected 2", any_mcnt); end

    pulse_start(1);
    store(32'd104, 32'd9);
    store(32'd104, 32'd9);
    n_cmp++; if (any_fail  !== 1'b1)   begin n_err++; $display("FAIL any_repeat_fail: got %0d expected 1", any_fail); end
    n_cmp++; if (any_code  !== 2'd1)   begin n_err++; $display("FAIL any_repeat_code: got %0d expected 1", any_code); end
    n_cmp++; if (any_faddr !== 32'd104) begin n_err++; $display("FAIL any_repeat_faddr: got %0d expected 104", any_faddr); end

    pulse_start(1);
    store(32'd104, 32'd9);
    store(32'd100, 32'd8);
    n_cmp++; if (any_code  !== 2'd2) begin n_err++; $display("FAIL any_baddata_code: got %0d expected 2", any_code); end
    n_cmp++; if (any_fdata !== 32'd8) begin n_err++; $display("FAIL any_baddata_fdata: got %0d expected 8", any_fdata); end
  endtask

  task automatic test_bad_data();
    pulse_start(0);
    n_cmp++; if (ord_fail  !== 1'b0)  begin n_err++; $display("FAIL clr_fail: got %0d expected 0", ord_fail); end
    n_cmp++; if (ord_code  !== 2'd0)  begin n_err++; $display("FAIL clr_code: got %0d expected 0", ord_code); end
    n_cmp++; if (ord_faddr !== 32'd0) begin n_err++; $display("FAIL clr_faddr: got %0d expected 0", ord_faddr); end
    n_cmp++; if (ord_fdata !== 32'd0) begin n_err++; $display("FAIL clr_fdata: got %0d expected 0", ord_fdata); end
    store(32'd100, 32'd8);
    n_cmp++; if (ord_code  !== 2'd2)   begin n_err++; $display("FAIL bd_code: got %0d expected 2", ord_code); end
    n_cmp++; if (ord_faddr !== 32'd100) begin n_err++; $display("FAIL bd_faddr: got %0d expected 100", ord_faddr); end
    n_cmp++; if (ord_fdata !== 32'd8)  begin n_err++; $display("FAIL bd_fdata: got %0d expected 8", ord_fdata); end
    pulse_start(0);
    store(32'd200, 32'd1);
    n_cmp++; if (ord_code  !== 2'd1)   begin n_err++; $display("FAIL ba_code: got %0d expected 1", ord_code); end
    n_cmp++; if (ord_faddr !== 32'd200) begin n_err++; $display("FAIL ba_faddr: got %0d expected 200", ord_faddr); end
    n_cmp++; if (ord_fdata !== 32'd1)  begin n_err++; $display("FAIL ba_fdata: got %0d expected 1", ord_fdata); end
  endtask

  task automatic test_timeout();
    pulse_start(2);
    repeat (19) tick();
    n_cmp++; if (to_busy !== 1'b1)   begin n_err++; $display("FAIL to_pre_busy: got %0d expected 1", to_busy); end
    n_cmp++; if (to_cyc  !== 16'd19) begin n_err++; $display("FAIL to_pre_cycles: got %0d expected 19", to_cyc); end
    n_cmp++; if (to_fail !== 1'b0)   begin n_err++; $display("FAIL to_pre_fail: got %0d expected 0", to_fail); end
    tick();
    n_cmp++; if (to_fail  !== 1'b1)  begin n_err++; $display("FAIL to_fail: got %0d expected 1", to_fail); end
    n_cmp++; if (to_code  !== 2'd3)  begin n_err++; $display("FAIL to_code: got %0d expected 3", to_code); end
    n_cmp++; if (to_faddr !== 32'd0) begin n_err++; $display("FAIL to_faddr: got %0d expected 0", to_faddr); end
    n_cmp++; if (to_fdata !== 32'd0) begin n_err++; $display("FAIL to_fdata: got %0d expected 0", to_fdata); end
    n_cmp++; if (to_busy  !== 1'b0)  begin n_err++; $display("FAIL to_busy: got %0d expected 0", to_busy); end

    pulse_start(2);
    store(32'd100, 32'd7);
    repeat (18) tick();
    n_cmp++; if (to_cyc  !== 16'd19) begin n_err++; $display("FAIL tolast_cycles: got %0d expected 19", to_cyc); end
    n_cmp++; if (to_mcnt !== 2'd1)   begin n_err++; $display("FAIL tolast_mcnt: got %0d expected 1", to_mcnt); end
    store(32'd104, 32'd9);
    n_cmp++; if (to_pass !== 1'b1) begin n_err++; $display("FAIL tolast_pass: got %0d expected 1", to_pass); end
    n_cmp++; if (to_fail !== 1'b0) begin n_err++; $display("FAIL tolast_fail: got %0d expected 0", to_fail); end
  endtask

  task automatic test_ignore_window();
    n_cmp++; if (ign_busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %0d expected 0", ign_busy); end
    n_cmp++; if (ign_fail !== 1'b0) begin n_err++; $display("FAIL idle_fail: got %0d expected 0", ign_fail); end
    n_cmp++; if (ign_mcnt !== 1'b0) begin n_err++; $display("FAIL idle_mcnt: got %0d expected 0", ign_mcnt); end
    pulse_start(3);
    store(32'd98, 32'd5);
    n_cmp++; if (ign_busy !== 1'b1) begin n_err++; $display("FAIL ign98_busy: got %0d expected 1", ign_busy); end
    n_cmp++; if (ign_fail !== 1'b0) begin n_err++; $display("FAIL ign98_fail: got %0d expected 0", ign_fail); end
    store(32'd103, 32'd1);
    n_cmp++; if (ign_busy !== 1'b1) begin n_err++; $display("FAIL ign103_busy: got %0d expected 1", ign_busy); end
    store(32'd100, 32'd7);
    n_cmp++; if (ign_pass !== 1'b1) begin n_err++; $display("FAIL ign_match_pass: got %0d expected 1", ign_pass); end
    n_cmp++; if (ign_mcnt !== 1'b1) begin n_err++; $display("FAIL ign_match_mcnt: got %0d expected 1", ign_mcnt); end
    pulse_start(3);
    store(32'd104, 32'd1);
    n_cmp++; if (ign_fail !== 1'b1) begin n_err++; $display("FAIL ign104_fail: got %0d expected 1", ign_fail); end
    n_cmp++; if (ign_code !== 2'd1) begin n_err++; $display("FAIL ign104_code: got %0d expected 1", ign_code); end
  endtask

  task automatic test_reset_midrun();
    pulse_start(0);
    store(32'd100, 32'd7);
    n_cmp++; if (ord_mcnt !== 2'd1) begin n_err++; $display("FAIL mid_mcnt: got %0d expected 1", ord_mcnt); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (ord_busy !== 1'b0)  begin n_err++; $display("FAIL mid_rst_busy: got %0d expected 0", ord_busy); end
    n_cmp++; if (ord_mcnt !== 2'd0)  begin n_err++; $display("FAIL mid_rst_mcnt: got %0d expected 0", ord_mcnt); end
    n_cmp++; if (ord_cyc  !== 16'd0) begin n_err++; $display("FAIL mid_rst_cycles: got %0d expected 0", ord_cyc); end
    n_cmp++; if (ord_pass !== 1'b0)  begin n_err++; $display("FAIL mid_rst_pass: got %0d expected 0", ord_pass); end
    n_cmp++; if (ord_fail !== 1'b0)  begin n_err++; $display("FAIL mid_rst_fail: got %0d expected 0", ord_fail); end
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (ord_busy !== 1'b0) begin n_err++; $display("FAIL post_rst_busy: got %0d expected 0", ord_busy); end
    n_cmp++; if (ord_fail !== 1'b0) begin n_err++; $display("FAIL post_rst_fail: got %0d expected 0", ord_fail); end
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    reset         = 1'b1;
    start_ord     = 1'b0;
    start_any     = 1'b0;
    start_to      = 1'b0;
    start_ign     = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.Adr       = '0;
    bus.WriteData = '0;
    exp2_addr     = {32'd104, 32'd100};
    exp2_data     = {32'd9, 32'd7};
    exp1_addr     = 32'd100;
    exp1_data     = 32'd7;

    test_reset();
    test_ordered_pass();
    test_order_violation();
    test_bad_data();
    test_timeout();
    test_ignore_window();
    test_reset_midrun();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
